// File: rtl/guard_motion.sv
// Guard sprite motion stage: steps the guard once per frame tick according to the direction
// command, pauses on turns, clamps to the arena and publishes a registered vision box.
module guard_motion #(
    parameter logic [9:0] START_X     = 10'd320,
    parameter logic [9:0] START_Y     = 10'd240,
    parameter logic [9:0] GUARD_S     = 10'd8,
    parameter logic [9:0] STEP        = 10'd1,
    parameter logic [9:0] X_MIN       = 10'd0,
    parameter logic [9:0] X_MAX       = 10'd639,
    parameter logic [9:0] Y_MIN       = 10'd0,
    parameter logic [9:0] Y_MAX       = 10'd479,
    parameter logic [9:0] VIS_LEN     = 10'd64,
    parameter logic [3:0] TURN_FRAMES = 4'd4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       enable,
    input  logic [2:0] direction_guard,
    output logic [9:0] GuardX,
    output logic [9:0] GuardY,
    output logic [9:0] GuardS,
    output logic [9:0] GuardSY,
    output logic [9:0] vision_startX,
    output logic [9:0] vision_startY,
    output logic [9:0] vision_endX,
    output logic [9:0] vision_endY,
    output logic [2:0] facing,
    output logic       hit_wall
);
    localparam logic [2:0] DIR_UP = 3'd1, DIR_DOWN = 3'd2, DIR_LEFT = 3'd3, DIR_RIGHT = 3'd4;

    localparam logic signed [11:0] GS   = $signed({2'b00, GUARD_S});
    localparam logic signed [11:0] ST   = $signed({2'b00, STEP});
    localparam logic signed [11:0] VL   = $signed({2'b00, VIS_LEN});
    localparam logic signed [11:0] XA_LO = $signed({2'b00, X_MIN});
    localparam logic signed [11:0] XA_HI = $signed({2'b00, X_MAX});
    localparam logic signed [11:0] YA_LO = $signed({2'b00, Y_MIN});
    localparam logic signed [11:0] YA_HI = $signed({2'b00, Y_MAX});
    localparam logic signed [11:0] X_LO = XA_LO + GS;
    localparam logic signed [11:0] X_HI = XA_HI - GS;
    localparam logic signed [11:0] Y_LO = YA_LO + GS;
    localparam logic signed [11:0] Y_HI = YA_HI - GS;

    // Reset vision box: START position facing down.
    localparam logic [9:0] RST_VSX = START_X - GUARD_S;
    localparam logic [9:0] RST_VEX = START_X + GUARD_S;
    localparam logic [9:0] RST_VSY = START_Y + GUARD_S;
    localparam logic [9:0] RST_VEY = START_Y + GUARD_S + VIS_LEN;

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_TURN} state_t;

    function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                         input logic signed [11:0] lo,
                                         input logic signed [11:0] hi);
        logic signed [11:0] r;
        r = (v < lo) ? lo : ((v > hi) ? hi : v);
        return r[9:0];
    endfunction

    logic       sync1_q, sync2_q, sync3_q;
    logic       tick;
    state_t     state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [2:0] facing_q, facing_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;
    logic [9:0] vsx_q, vsx_d, vsy_q, vsy_d, vex_q, vex_d, vey_q, vey_d;
    logic       dir_valid, do_step;
    logic signed [11:0] nx, ny;

    assign tick      = sync2_q & ~sync3_q;
    assign dir_valid = (direction_guard >= DIR_UP) && (direction_guard <= DIR_RIGHT);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        facing_d = facing_q;
        cnt_d    = cnt_q;
        hit_d    = 1'b0;
        do_step  = 1'b0;
        nx       = $signed({2'b00, x_q});
        ny       = $signed({2'b00, y_q});

        if (tick && enable) begin
            case (state_q)
                S_TURN: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (!dir_valid) begin
                        state_d = S_IDLE;
                    end else if (direction_guard == facing_q) begin
                        // Turn pause is TURN_FRAMES ticks; the release tick already moves.
                        state_d = S_MOVE;
                        do_step = 1'b1;
                    end else begin
                        facing_d = direction_guard;
                        cnt_d    = TURN_FRAMES - 4'd1;
                    end
                end
                default: begin
                    if (!dir_valid) begin
                        state_d = S_IDLE;
                    end else if (direction_guard == facing_q) begin
                        state_d = S_MOVE;
                        do_step = 1'b1;
                    end else begin
                        state_d  = S_TURN;
                        facing_d = direction_guard;
                        cnt_d    = TURN_FRAMES - 4'd1;
                    end
                end
            endcase
        end

        if (do_step) begin
            case (facing_q)
                DIR_UP:    ny = ny - ST;
                DIR_DOWN:  ny = ny + ST;
                DIR_LEFT:  nx = nx - ST;
                DIR_RIGHT: nx = nx + ST;
                default:   ;
            endcase
            if (nx < X_LO || nx > X_HI || ny < Y_LO || ny > Y_HI) hit_d = 1'b1;
            x_d = clamp(nx, X_LO, X_HI);
            y_d = clamp(ny, Y_LO, Y_HI);
        end
    end

    // Vision box follows the registered position/facing, so it lags them by one Clk.
    always_comb begin
        logic signed [11:0] xs, ys;
        xs = $signed({2'b00, x_q});
        ys = $signed({2'b00, y_q});
        vsx_d = clamp(xs - GS, XA_LO, XA_HI);
        vex_d = clamp(xs + GS, XA_LO, XA_HI);
        vsy_d = clamp(ys + GS, YA_LO, YA_HI);
        vey_d = clamp(ys + GS + VL, YA_LO, YA_HI);
        case (facing_q)
            DIR_UP: begin
                vsy_d = clamp(ys - GS - VL, YA_LO, YA_HI);
                vey_d = clamp(ys - GS, YA_LO, YA_HI);
            end
            DIR_LEFT: begin
                vsx_d = clamp(xs - GS - VL, XA_LO, XA_HI);
                vex_d = clamp(xs - GS, XA_LO, XA_HI);
                vsy_d = clamp(ys - GS, YA_LO, YA_HI);
                vey_d = clamp(ys + GS, YA_LO, YA_HI);
            end
            DIR_RIGHT: begin
                vsx_d = clamp(xs + GS, XA_LO, XA_HI);
                vex_d = clamp(xs + GS + VL, XA_LO, XA_HI);
                vsy_d = clamp(ys - GS, YA_LO, YA_HI);
                vey_d = clamp(ys + GS, YA_LO, YA_HI);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            state_q  <= S_IDLE;
            x_q      <= START_X;
            y_q      <= START_Y;
            facing_q <= DIR_DOWN;
            cnt_q    <= 4'd0;
            hit_q    <= 1'b0;
            vsx_q    <= RST_VSX;
            vsy_q    <= RST_VSY;
            vex_q    <= RST_VEX;
            vey_q    <= RST_VEY;
        end else begin
            sync1_q  <= frame_clk;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            facing_q <= facing_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            vsx_q    <= vsx_d;
            vsy_q    <= vsy_d;
            vex_q    <= vex_d;
            vey_q    <= vey_d;
        end
    end

    assign GuardX        = x_q;
    assign GuardY        = y_q;
    assign GuardS        = GUARD_S;
    assign GuardSY       = GUARD_S;
    assign facing        = facing_q;
    assign hit_wall      = hit_q;
    assign vision_startX = vsx_q;
    assign vision_startY = vsy_q;
    assign vision_endX   = vex_q;
    assign vision_endY   = vey_q;
endmodule
